xy_switch_control: RTL and testbench

- Central switch controller for the 5-port credit-based mesh router.
- Selects one pending input header at a time with a round-robin arbiter and computes the XY route from the header flit.
- Allocates the requested output when it is free and drives crossbar select signals (mux_in/mux_out), the one-hot header acknowledge, and per-output free flags.
- Releases a connection when its input buffer stops sending.

---
 rtl/xy_switch_control_if.sv | 25 ++
 rtl/xy_switch_control.sv | 143 ++++++++++++++
 tb/tb_xy_switch_control.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xy_switch_control_if.sv
// rtl/xy_switch_control_if.sv - switch-control bus: header requests, head flits, crossbar selects and free flags
interface xy_switch_control_if #(
  parameter int NPORT      = 5,
  parameter int FLIT_WIDTH = 16,
  parameter int METADEFLIT = 8
);
  logic [NPORT-1:0]            h;
  logic [NPORT*FLIT_WIDTH-1:0] data;
  logic [NPORT-1:0]            sender;
  logic [METADEFLIT-1:0]       address;
  logic [NPORT-1:0]            ack_h;
  logic [NPORT-1:0]            free;
  logic [NPORT*3-1:0]          mux_in;
  logic [NPORT*3-1:0]          mux_out;

  modport master (
    output h, data, sender, address,
    input  ack_h, free, mux_in, mux_out
  );

  modport slave (
    input  h, data, sender, address,
    output ack_h, free, mux_in, mux_out
  );
endinterface

// File: rtl/xy_switch_control.sv
// rtl/xy_switch_control.sv - round-robin XY switch allocator for the 5-port mesh router
// Optional refused-grant counter enabled by SWITCH_BLOCK_CNT_EN.
module xy_switch_control #(
  parameter int NPORT      = 5,
  parameter int FLIT_WIDTH = 16,
  parameter int METADEFLIT = 8
) (
  input  logic                clock_i,
  input  logic                reset_i,
`ifdef SWITCH_BLOCK_CNT_EN
  output logic [15:0]         blocked_cnt_o,
`endif
  xy_switch_control_if.slave  sw
);
  localparam int HW = METADEFLIT / 2;
  localparam logic [2:0] EAST  = 3'd0;
  localparam logic [2:0] WEST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_ROUTE, S_GRANT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       last_q, last_d;
  logic [2:0]       dir_q, dir_d;
  logic [NPORT-1:0] free_q;
  logic [2:0]       mux_in_q  [NPORT];
  logic [2:0]       mux_out_q [NPORT];

  logic [METADEFLIT-1:0] target;
  logic [HW-1:0]         tx, ty, lx, ly;
  logic                  grant;
  logic                  found;
  logic [2:0]            pick;

  assign target = sw.data[int'(sel_q)*FLIT_WIDTH +: METADEFLIT];
  assign tx     = target[METADEFLIT-1:HW];
  assign ty     = target[HW-1:0];
  assign lx     = sw.address[METADEFLIT-1:HW];
  assign ly     = sw.address[HW-1:0];
  // Grant decision uses the registered free flag, so a same-cycle release is never double-booked.
  assign grant  = (state_q == S_GRANT) && free_q[dir_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    dir_d   = dir_q;
    found   = 1'b0;
    pick    = '0;
    case (state_q)
      S_IDLE: if (|sw.h) state_d = S_SELECT;
      S_SELECT: begin
        // Rotating priority: indices above last first, then wrap to the low indices.
        for (int i = 0; i < NPORT; i++) begin
          if (!found && sw.h[i] && (3'(i) > last_q)) begin
            found = 1'b1;
            pick  = 3'(i);
          end
        end
        for (int i = 0; i < NPORT; i++) begin
          if (!found && sw.h[i]) begin
            found = 1'b1;
            pick  = 3'(i);
          end
        end
        if (found) begin
          sel_d   = pick;
          last_d  = pick;
          state_d = S_ROUTE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ROUTE: begin
        if (tx > lx)      dir_d = EAST;
        else if (tx < lx) dir_d = WEST;
        else if (ty > ly) dir_d = NORTH;
        else if (ty < ly) dir_d = SOUTH;
        else              dir_d = LOCAL;
        state_d = S_GRANT;
      end
      S_GRANT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sw.ack_h = '0;
    if (grant) sw.ack_h[sel_q] = 1'b1;
    for (int o = 0; o < NPORT; o++) begin
      sw.mux_in[o*3 +: 3]  = mux_in_q[o];
      sw.mux_out[o*3 +: 3] = mux_out_q[o];
    end
  end

  assign sw.free = free_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      last_q  <= LOCAL;
      dir_q   <= '0;
      free_q  <= '1;
      for (int o = 0; o < NPORT; o++) begin
        mux_in_q[o]  <= '0;
        mux_out_q[o] <= '0;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
      for (int o = 0; o < NPORT; o++) begin
        if (!free_q[o] && !sw.sender[mux_in_q[o]]) free_q[o] <= 1'b1;
      end
      if (grant) begin
        free_q[dir_q]    <= 1'b0;
        mux_in_q[dir_q]  <= sel_q;
        mux_out_q[sel_q] <= dir_q;
      end
    end
  end

`ifdef SWITCH_BLOCK_CNT_EN
  logic        refuse;
  logic [15:0] blocked_cnt_q;

  assign refuse = (state_q == S_GRANT) && !free_q[dir_q];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)
      blocked_cnt_q <= '0;
    else if (refuse && (blocked_cnt_q != 16'hFFFF))
      blocked_cnt_q <= blocked_cnt_q + 16'd1;
  end

  assign blocked_cnt_o = blocked_cnt_q;
`endif
endmodule

// File: tb/tb_xy_switch_control.sv
// tb/tb_xy_switch_control.sv - scoreboard bench for xy_switch_control with a transaction-level allocation model
`timescale 1ns/1ps
module tb_xy_switch_control;
  localparam int NPORT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xy_switch_control_if bus ();
`ifdef SWITCH_BLOCK_CNT_EN
  logic [15:0] blocked_cnt;
`endif

  xy_switch_control dut (
    .clock_i       (clk),
    .reset_i       (rst),
`ifdef SWITCH_BLOCK_CNT_EN
    .blocked_cnt_o (blocked_cnt),
`endif
    .sw            (bus)
  );

  typedef struct {
    int in_p;
    int out_p;
  } grant_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  grant_t exp_q[$];
  int     ack_cyc_q[$];
  int     last_ack_cyc = 0;
  int     owner [NPORT];
  int     model_last = 4;
  bit     pend_chk = 0;
  int     pend_in, pend_out;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int route(logic [7:0] t, logic [7:0] a);
    if (t[7:4] > a[7:4]) return 0;
    if (t[7:4] < a[7:4]) return 1;
    if (t[3:0] > a[3:0]) return 2;
    if (t[3:0] < a[3:0]) return 3;
    return 4;
  endfunction

  function automatic logic [7:0] gen_target(int d, logic [3:0] lx, logic [3:0] ly);
    logic [3:0] tx, ty;
    tx = lx;
    ty = ly;
    case (d)
      0: begin tx = 4'($urandom_range(int'(lx) + 1, 15)); ty = 4'($urandom); end
      1: begin tx = 4'($urandom_range(0, int'(lx) - 1)); ty = 4'($urandom); end
      2: ty = 4'($urandom_range(int'(ly) + 1, 15));
      3: ty = 4'($urandom_range(0, int'(ly) - 1));
      default: ;
    endcase
    return {tx, ty};
  endfunction

  function automatic logic [4:0] model_free();
    logic [4:0] f;
    for (int o = 0; o < NPORT; o++) f[o] = (owner[o] < 0);
    return f;
  endfunction

  function automatic bit owns(int i);
    for (int o = 0; o < NPORT; o++) if (owner[o] == i) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit owners_distinct();
    for (int a = 0; a < NPORT; a++)
      for (int b = a + 1; b < NPORT; b++)
        if (!bus.free[a] && !bus.free[b] && bus.mux_in[a*3 +: 3] == bus.mux_in[b*3 +: 3]) return 1'b0;
    return 1'b1;
  endfunction

  // Serve a set of simultaneous requests in rotating order; each served request claims its output.
  task automatic run_batch(input logic [4:0] mask);
    logic [4:0] p;
    int guard, pick, d, idx;
    grant_t g;
    p = mask;
    guard = 0;
    while (p != 0 && guard < 50) begin
      pick = -1;
      for (int k = 1; k <= NPORT; k++) begin
        idx = (model_last + k) % NPORT;
        if (pick < 0 && p[idx]) pick = idx;
      end
      model_last = pick;
      d = route(bus.data[pick*16 +: 8], bus.address);
      if (owner[d] < 0) begin
        g.in_p = pick;
        g.out_p = d;
        exp_q.push_back(g);
        owner[d] = pick;
        p[pick] = 1'b0;
      end
      guard++;
    end
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d grants outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    step(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    bus.h = '0;
    bus.sender = '0;
    for (int o = 0; o < NPORT; o++) owner[o] = -1;
    model_last = 4;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every grant pulse and checks the allocation one cycle later.
  initial forever begin
    int ai;
    grant_t g;
    @(negedge clk);
    if (rst) begin
      pend_chk = 0;
    end else begin
      if (pend_chk) begin
        check("grant_free", int'(bus.free[pend_out]), 0);
        check("grant_mux_in", int'(bus.mux_in[pend_out*3 +: 3]), pend_in);
        check("grant_mux_out", int'(bus.mux_out[pend_in*3 +: 3]), pend_out);
        pend_chk = 0;
      end
      check("ack_onehot0", int'($onehot0(bus.ack_h)), 1);
      check("owners_distinct", int'(owners_distinct()), 1);
      if (bus.ack_h != 0) begin
        ai = 0;
        for (int i = NPORT - 1; i >= 0; i--) if (bus.ack_h[i]) ai = i;
        ack_cyc_q.push_back(cyc);
        last_ack_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack on port %0d, required no grant", ai);
        end else begin
          g = exp_q.pop_front();
          check("ack_port", ai, g.in_p);
          pend_in = g.in_p;
          pend_out = g.out_p;
          pend_chk = 1;
        end
        bus.h[ai] = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, d0, dcount, nsel;
    int ins[$], outs[$];
    logic [4:0] mask, fbefore, fafter;
    logic [3:0] lx, ly;
`ifdef SWITCH_BLOCK_CNT_EN
    logic [15:0] b0;
`endif
    bus.h = '0;
    bus.sender = '0;
    bus.data = '0;
    bus.address = '0;
    for (int o = 0; o < NPORT; o++) owner[o] = -1;
    step(3);
    check("reset_free", int'(bus.free), 5'b11111);
    check("reset_ack", int'(bus.ack_h), 0);
    check("reset_mux_in", int'(bus.mux_in), 0);
    check("reset_mux_out", int'(bus.mux_out), 0);
`ifdef SWITCH_BLOCK_CNT_EN
    check("reset_blocked_cnt", int'(blocked_cnt), 0);
`endif
    rst = 1'b0;
    step(2);

    // Single route: WEST header to 0x21 from router 0x11 goes EAST, ack on 3rd cycle.
    bus.address = 8'h11;
    bus.data[1*16 +: 16] = 16'h0021;
    bus.sender[1] = 1'b1;
    run_batch(5'b00010);
    n0 = cyc;
    bus.h[1] = 1'b1;
    wait_drain(20);
    check("single_latency", last_ack_cyc - n0, 3);

    // Local delivery then release.
    bus.data[3*16 +: 16] = 16'h0011;
    bus.sender[3] = 1'b1;
    run_batch(5'b01000);
    bus.h[3] = 1'b1;
    wait_drain(20);
    bus.sender[3] = 1'b0;
    owner[4] = -1;
    @(negedge clk);
    check("local_release_hold", int'(bus.free[4]), 0);
    @(negedge clk);
    check("local_release_free", int'(bus.free[4]), 1);
    @(posedge clk);
    #1;
    bus.sender[1] = 1'b0;
    owner[0] = -1;
    step(2);

    // Reset while three connections are active and a fourth request is in S_ROUTE.
    do_reset();
    bus.address = 8'h11;
    bus.data[0*16 +: 16] = 16'h0021;
    bus.data[1*16 +: 16] = 16'h0001;
    bus.data[2*16 +: 16] = 16'h0012;
    bus.sender = 5'b00111;
    run_batch(5'b00111);
    bus.h = 5'b00111;
    wait_drain(40);
    bus.data[4*16 +: 16] = 16'h0010;
    bus.sender[4] = 1'b1;
    bus.h[4] = 1'b1;
    step(2);
    rst = 1'b1;
    #1;
    check("midreset_free", int'(bus.free), 5'b11111);
    check("midreset_ack", int'(bus.ack_h), 0);
    check("midreset_mux_in", int'(bus.mux_in), 0);
    check("midreset_mux_out", int'(bus.mux_out), 0);
    exp_q.delete();
    for (int o = 0; o < NPORT; o++) owner[o] = -1;
    model_last = 4;
    bus.data[3*16 +: 16] = 16'h0010;
    bus.sender = 5'b01110;
    bus.h = 5'b01110;
    step(2);
    rst = 1'b0;
    run_batch(5'b01110);
    if (exp_q.size() != 0) check("midreset_first_grant_model", exp_q[0].in_p, 1);
    wait_drain(60);

    // Round-robin fairness from reset with all five inputs requesting distinct outputs.
    do_reset();
    bus.address = 8'h11;
    bus.data[0*16 +: 16] = 16'h0021;
    bus.data[1*16 +: 16] = 16'h0001;
    bus.data[2*16 +: 16] = 16'h0012;
    bus.data[3*16 +: 16] = 16'h0010;
    bus.data[4*16 +: 16] = 16'h0011;
    bus.sender = 5'b11111;
    ack_cyc_q.delete();
    run_batch(5'b11111);
    bus.h = 5'b11111;
    wait_drain(60);
    check("rr_grant_count", ack_cyc_q.size(), 5);
    for (int k = 1; k < 5; k++)
      if (k < ack_cyc_q.size()) check("rr_spacing", ack_cyc_q[k] - ack_cyc_q[k-1], 4);

    // Contention: NORTH and SOUTH both want EAST.
    do_reset();
    bus.address = 8'h11;
    bus.data[2*16 +: 16] = 16'h0031;
    bus.data[3*16 +: 16] = 16'h0031;
    bus.sender = 5'b01100;
    begin
      grant_t g;
      g.in_p = 2; g.out_p = 0;
      exp_q.push_back(g);
    end
    bus.h = 5'b01100;
    wait_drain(40);
`ifdef SWITCH_BLOCK_CNT_EN
    b0 = blocked_cnt;
    step(8);
    check("contention_blocked_step", int'(blocked_cnt - b0), 2);
`else
    step(8);
`endif
    check("contention_east_held", int'(bus.free[0]), 0);
    check("contention_south_pending", int'(bus.h[3]), 1);
    begin
      grant_t g;
      g.in_p = 3; g.out_p = 0;
      exp_q.push_back(g);
    end
    d0 = cyc;
    bus.sender[2] = 1'b0;
    wait_drain(40);
    check("contention_retry_window", int'(last_ack_cyc >= d0 + 1 && last_ack_cyc <= d0 + 5), 1);

    // Owner of EAST stops sending exactly in the S_GRANT cycle of a new EAST request.
    step(2);
`ifdef SWITCH_BLOCK_CNT_EN
    b0 = blocked_cnt;
`endif
    bus.data[4*16 +: 16] = 16'h0031;
    bus.sender[4] = 1'b1;
    begin
      grant_t g;
      g.in_p = 4; g.out_p = 0;
      exp_q.push_back(g);
    end
    n0 = cyc;
    bus.h[4] = 1'b1;
    step(3);
    bus.sender[3] = 1'b0;
    wait_drain(40);
    check("sameedge_ack_cycle", last_ack_cyc - n0, 7);
`ifdef SWITCH_BLOCK_CNT_EN
    check("sameedge_blocked", int'(blocked_cnt - b0), 1);
`endif

    // Randomized rounds: fresh requests onto free outputs, then random releases.
    do_reset();
    for (int r = 0; r < 25; r++) begin
      lx = 4'($urandom_range(1, 14));
      ly = 4'($urandom_range(1, 14));
      bus.address = {lx, ly};
      ins.delete();
      outs.delete();
      for (int i = 0; i < NPORT; i++) if (!owns(i)) ins.push_back(i);
      for (int o = 0; o < NPORT; o++) if (owner[o] < 0) outs.push_back(o);
      nsel = (ins.size() < outs.size()) ? ins.size() : outs.size();
      if (nsel > 0) nsel = $urandom_range(1, nsel);
      mask = '0;
      for (int k = 0; k < nsel; k++) begin
        int a, b, i, o;
        a = $urandom_range(0, ins.size() - 1);
        i = ins[a];
        ins.delete(a);
        b = $urandom_range(0, outs.size() - 1);
        o = outs[b];
        outs.delete(b);
        bus.data[i*16 +: 16] = {8'($urandom), gen_target(o, lx, ly)};
        bus.sender[i] = 1'b1;
        mask[i] = 1'b1;
      end
      if (mask != 0) begin
        run_batch(mask);
        bus.h = mask;
        wait_drain(40 * nsel);
      end
      fbefore = model_free();
      dcount = 0;
      for (int o = 0; o < NPORT; o++) begin
        if (owner[o] >= 0 && $urandom_range(0, 1) == 1) begin
          bus.sender[owner[o]] = 1'b0;
          owner[o] = -1;
          dcount++;
        end
      end
      fafter = model_free();
      @(negedge clk);
      check("rand_free_before", int'(bus.free), int'(fbefore));
      @(negedge clk);
      check("rand_free_after", int'(bus.free), int'(fafter));
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
